seg7_mux_display: RTL and testbench

Four-digit multiplexed seven-segment display driver, placed directly downstream of the 1 Hz binary counter on the 50 MHz Basys2 board. It captures a 16-bit value (four hex nibbles; the counter's 4-bit Q feeds nibble 0 with the upper nibbles tied to zero), decodes each nibble to segments, and time-multiplexes the four common anodes. It adds a one-cycle anode dead time between digits and optional leading-zero blanking. All outputs are active-low to match the board.

---
 rtl/seg7_mux_display_if.sv | 21 ++
 rtl/seg7_mux_display.sv | 107 ++++++++++
 tb/tb_seg7_mux_display.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/seg7_mux_display_if.sv
// Display-side bundle: value/load/dp/blank requests in,
// active-low anode, segment and decimal point drive out.
interface seg7_mux_display_if;
   logic [15:0] Value;
   logic        Load;
   logic [3:0]  DpIn;
   logic        BlankLz;
   logic [3:0]  An;
   logic [6:0]  Seg;
   logic        Dp;

   modport master (
      output Value, Load, DpIn, BlankLz,
      input  An, Seg, Dp
   );

   modport slave (
      input  Value, Load, DpIn, BlankLz,
      output An, Seg, Dp
   );
endinterface

// File: rtl/seg7_mux_display.sv
// Four-digit multiplexed seven-segment driver with one-cycle
// anode dead time and optional leading-zero blanking.
module seg7_mux_display #(
   parameter int RefreshDiv = 50_000,
   parameter int CntBits    = 16
) (
   input logic               Clk,
   input logic               Clr,
   seg7_mux_display_if.slave bus
);

   logic [15:0]        shadow;
   logic [3:0]         dp_shadow;
   logic [CntBits-1:0] count;
   logic [1:0]         sel;

   logic [CntBits-1:0] count_nx;
   logic [1:0]         sel_nx;
   logic [3:0]         nib;
   logic [3:0]         lz;
   logic               blank;
   logic [3:0]         an_nx;
   logic [6:0]         seg_nx;
   logic               dp_nx;

   function automatic logic [6:0] decode(input logic [3:0] n);
      logic [6:0] s;
      s = 7'b1111111;
      unique case (n)
         4'h0: s = 7'b1000000;
         4'h1: s = 7'b1111001;
         4'h2: s = 7'b0100100;
         4'h3: s = 7'b0110000;
         4'h4: s = 7'b0011001;
         4'h5: s = 7'b0010010;
         4'h6: s = 7'b0000010;
         4'h7: s = 7'b1111000;
         4'h8: s = 7'b0000000;
         4'h9: s = 7'b0010000;
         4'hA: s = 7'b0001000;
         4'hB: s = 7'b0000011;
         4'hC: s = 7'b1000110;
         4'hD: s = 7'b0100001;
         4'hE: s = 7'b0000110;
         4'hF: s = 7'b0001110;
      endcase
      return s;
   endfunction

   // lz[k]: nibbles k..3 are all zero (digit 0 never qualifies)
   always_comb begin
      lz    = 4'b0000;
      lz[1] = ~|shadow[15:4];
      lz[2] = ~|shadow[15:8];
      lz[3] = ~|shadow[15:12];
   end

   // Outputs are derived from the post-edge count/sel so they
   // line up with the prescaler state they are shown in.
   always_comb begin
      count_nx = count + 1'b1;
      sel_nx   = sel;
      if (count == CntBits'(RefreshDiv - 1)) begin
         count_nx = '0;
         sel_nx   = sel + 2'd1;
      end
      nib    = shadow[{sel_nx, 2'b00} +: 4];
      blank  = bus.BlankLz & lz[sel_nx];
      an_nx  = 4'b1111;
      seg_nx = 7'b1111111;
      dp_nx  = 1'b1;
      if (count_nx != '0) begin
         an_nx = ~(4'b0001 << sel_nx);
         if (!blank) begin
            seg_nx = decode(nib);
            dp_nx  = ~dp_shadow[sel_nx];
         end
      end
   end

   always_ff @(posedge Clk or posedge Clr) begin
      if (Clr) begin
         shadow    <= '0;
         dp_shadow <= '0;
      end else if (bus.Load) begin
         shadow    <= bus.Value;
         dp_shadow <= bus.DpIn;
      end
   end

   always_ff @(posedge Clk or posedge Clr) begin
      if (Clr) begin
         count   <= '0;
         sel     <= '0;
         bus.An  <= 4'b1111;
         bus.Seg <= 7'b1111111;
         bus.Dp  <= 1'b1;
      end else begin
         count   <= count_nx;
         sel     <= sel_nx;
         bus.An  <= an_nx;
         bus.Seg <= seg_nx;
         bus.Dp  <= dp_nx;
      end
   end

endmodule

// File: tb/tb_seg7_mux_display.sv
// Directed bench for seg7_mux_display at RefreshDiv=4:
// rotation, decode, blanking, load latency, async clear.
module tb_seg7_mux_display;

   logic Clk = 1'b0;
   logic Clr = 1'b0;
   int   n_cmp = 0;
   int   n_bad = 0;
   int   edge_n = 0;

   seg7_mux_display_if bus ();

   seg7_mux_display #(
      .RefreshDiv (4),
      .CntBits    (3)
   ) dut (
      .Clk (Clk),
      .Clr (Clr),
      .bus (bus)
   );

   always #5 Clk = ~Clk;

   logic [3:0] an_tab [16] = '{
      4'b1110, 4'b1110, 4'b1110, 4'b1111,
      4'b1101, 4'b1101, 4'b1101, 4'b1111,
      4'b1011, 4'b1011, 4'b1011, 4'b1111,
      4'b0111, 4'b0111, 4'b0111, 4'b1111
   };

   logic [6:0] seg_tab [16] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
   };

   task automatic check(input string tag,
                        input logic [15:0] got,
                        input logic [15:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h (edge %0d)",
                  tag, got, exp, edge_n);
      end
   endtask

   task automatic step();
      @(posedge Clk);
      #1;
      edge_n++;
   endtask

   task automatic align();
      step();
      while (edge_n % 16 != 0) step();
   endtask

   // One full frame; digit k expects segment s[k] and Dp pin dpn[k].
   task automatic check_frame(input logic [6:0] s0,
                              input logic [6:0] s1,
                              input logic [6:0] s2,
                              input logic [6:0] s3,
                              input logic [3:0] dpn);
      logic [6:0] s [4];
      logic [3:0] an_exp;
      int c, d;
      s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
      repeat (16) begin
         step();
         c = edge_n % 4;
         d = (edge_n / 4) % 4;
         if (c == 0) begin
            check("dead an", {12'b0, bus.An}, 16'h000F);
            check("dead seg", {9'b0, bus.Seg}, 16'h007F);
            check("dead dp", {15'b0, bus.Dp}, 16'h0001);
         end else begin
            an_exp = 4'b1111;
            an_exp[d] = 1'b0;
            check($sformatf("an d%0d", d),
                  {12'b0, bus.An}, {12'b0, an_exp});
            check($sformatf("seg d%0d", d),
                  {9'b0, bus.Seg}, {9'b0, s[d]});
            check($sformatf("dp d%0d", d),
                  {15'b0, bus.Dp}, {15'b0, dpn[d]});
         end
      end
   endtask

   initial begin
      bus.Value   = 16'h0000;
      bus.Load    = 1'b0;
      bus.DpIn    = 4'b0000;
      bus.BlankLz = 1'b0;
      #3 Clr = 1'b1;
      repeat (2) @(posedge Clk);
      #1;
      check("rst an", {12'b0, bus.An}, 16'h000F);
      check("rst seg", {9'b0, bus.Seg}, 16'h007F);
      check("rst dp", {15'b0, bus.Dp}, 16'h0001);

      Clr = 1'b0;
      edge_n = 0;
      for (int i = 0; i < 16; i++) begin
         step();
         check($sformatf("rot %0d", i),
               {12'b0, bus.An}, {12'b0, an_tab[i]});
         if (i == 0)
            check("first seg", {9'b0, bus.Seg}, 16'h0040);
      end

      bus.Value = 16'hFA50;
      bus.DpIn  = 4'b0100;
      bus.Load  = 1'b1;
      step();
      bus.Load  = 1'b0;
      bus.DpIn  = 4'b0000;
      align();
      check_frame(7'b1000000, 7'b0010010, 7'b0001000,
                  7'b0001110, 4'b1011);

      bus.BlankLz = 1'b1;
      bus.Value   = 16'h0005;
      bus.Load    = 1'b1;
      step();
      bus.Load    = 1'b0;
      align();
      check_frame(7'b0010010, 7'b1111111, 7'b1111111,
                  7'b1111111, 4'b1111);

      bus.Value = 16'h0105;
      bus.Load  = 1'b1;
      step();
      bus.Load  = 1'b0;
      align();
      check_frame(7'b0010010, 7'b1000000, 7'b1111001,
                  7'b1111111, 4'b1111);

      bus.BlankLz = 1'b0;
      bus.Value   = 16'h0003;
      align();
      check_frame(7'b0010010, 7'b1000000, 7'b1111001,
                  7'b1000000, 4'b1111);

      while (edge_n % 16 != 1) step();
      bus.Load = 1'b1;
      step();
      bus.Load = 1'b0;
      check("load edge N", {9'b0, bus.Seg}, 16'h0012);
      step();
      check("load edge N+1", {9'b0, bus.Seg}, 16'h0030);

      while (edge_n % 16 != 10) step();
      check("pre clr an", {12'b0, bus.An}, 16'h000B);
      #2 Clr = 1'b1;
      #1;
      check("clr an", {12'b0, bus.An}, 16'h000F);
      check("clr seg", {9'b0, bus.Seg}, 16'h007F);
      check("clr dp", {15'b0, bus.Dp}, 16'h0001);
      step();
      step();
      Clr = 1'b0;
      edge_n = 0;
      step();
      check("post clr an", {12'b0, bus.An}, 16'h000E);
      check("post clr seg", {9'b0, bus.Seg}, 16'h0040);

      bus.BlankLz = 1'b1;
      bus.Load    = 1'b1;
      for (int q = 0; q <= 16; q++) begin
         bus.Value = {12'b0, 4'(q)};
         align();
         check_frame(seg_tab[q % 16], 7'b1111111, 7'b1111111,
                     7'b1111111, 4'b1111);
      end
      bus.Load = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
